xchk_lane_sched: RTL
====================

Name: xchk_lane_sched

Overview:
- Scheduler that drives the lane select of the 32-bit bus X-checker and samples the bus for X/Z per lane.
- Holds off for a startup window, then round-robins over the enabled lanes: byte 0, byte 1, byte 2, byte 3, full word.
- Records sticky per-lane error flags, a saturating error count, and the first failing lane.
- Sits beside the bus X-checker in the testbench/monitor layer. It is a simulation-only construct.

Parameters:
- STARTUP_CYCLES, 400: clock cycles after enable before the first sample.
- DWELL_CYCLES, 4: cycles spent on each lane. Range 1..255. The sample is taken on the last dwell cycle.
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  run scheduler; 0 forces IDLE
- lane_mask  in  5  bit i enables lane i (0..3 = byte i, 4 = full word)
- clear_errs  in  1  one-cycle pulse; clears error flags, count and first-error capture
- bus  in  32  observed data bus
- select  out  4  lane select: 0001/0010/0100/1000 for bytes, 1111 for word, 0000 when idle
- sample_valid  out  1  one-cycle pulse when a lane is sampled
- err_flags  out  5  sticky per-lane X-detected flags
- err_count  out  ERR_CNT_W  saturating count of X samples
- first_err_lane  out  3  lane index of the first error since the last clear
- first_err_valid  out  1  first_err_lane is meaningful
- busy  out  1  state is STARTUP or SCAN

Behaviour:
- Reset values: all outputs 0, state IDLE, lane pointer 0, all counters 0.
- IDLE:
  - select=0.
  - When enable=1, go to STARTUP and clear the startup counter.
- STARTUP:
  - Count STARTUP_CYCLES cycles. select=0.
  - At terminal count, go to SCAN with the pointer on the lowest enabled lane and the dwell counter at 0.
- SCAN:
  - select = encoding of the pointer lane.
  - The dwell counter increments each cycle.
  - On dwell == DWELL_CYCLES-1:
    - Sample the bus slice for the lane. X is detected when the reduction-XOR of the slice is X.
    - Pulse sample_valid.
    - Advance the pointer to the next enabled lane, searching upward and wrapping 4 to 0. With one enabled lane, stay on it.
    - Reset the dwell counter.
- lane_mask == 0 in SCAN:
  - select=0, no samples, the dwell counter is held.
  - Resume at the lowest enabled lane on the first cycle the mask becomes non-zero.
- lane_mask change mid-dwell:
  - If the current lane is still enabled, the sample is taken as normal.
  - If the current lane is no longer enabled at the sample cycle, suppress the sample (no sample_valid) and still advance.
- Error capture, registered one cycle after the sample:
  - Set err_flags[lane].
  - Increment err_count, saturating at all-ones.
  - If first_err_valid=0, load first_err_lane and set first_err_valid.
- clear_errs and error capture in the same cycle: the clear is applied first, then the new error is recorded (flag=1, count=1, first lane = this lane).
- enable falling in any state:
  - Go to IDLE on the next cycle; select=0 that cycle.
  - Error state is retained.
  - On re-enable, STARTUP restarts fully.
- reset mid-operation: the next cycle equals the reset state, including error state.
- Latency:
  - select changes on the cycle after the sample cycle.
  - The first sample occurs at cycle STARTUP_CYCLES + DWELL_CYCLES after enable is seen.

Decomposition:
- Package xchk_pkg:
  - Lane index enum: LANE_B0..LANE_B3, LANE_W.
  - Constant array of select encodings per lane.
  - State enum: IDLE, STARTUP, SCAN.
  - NUM_LANES = 5.
- Sub-module xchk_lane_picker: combinational round-robin next-enabled-lane finder (inputs: current lane, mask; outputs: next lane, any_enabled). Used for both initial lane selection and advance.

Test Plan:
- Startup and scan order: reset, enable=1, mask=5'b11111, STARTUP_CYCLES=400, DWELL=4, clean bus.
  - select=0 for 400 cycles.
  - Then 0001, 0010, 0100, 1000, 1111, each for 4 cycles, repeating.
  - sample_valid every 4 cycles, no errors.
- Byte X detection: bus[15:8]=8'hxx, all other bits 0, mask=5'b11111.
  - err_flags=5'b10010 after the first scan (byte 1 and word).
  - first_err_lane=1, first_err_valid=1, err_count=2 per full rotation.
- Sparse mask wrap: mask=5'b10100.
  - select alternates 0100, 1111, 0100.
  - mask=5'b00000 gives select=0 and no sample_valid.
  - mask=5'b00001 resumes on 0001.
- Saturation and simultaneous clear: ERR_CNT_W=2 with continuous X.
  - err_count stops at 3.
  - clear_errs on the same cycle as an error capture gives err_count=1 and a fresh first_err_lane.
- Disable and reset mid-scan:
  - enable=0 mid-dwell gives IDLE and select=0 next cycle, err_flags kept.
  - Re-enable waits a full 400 cycles.
  - reset=1 mid-scan clears all outputs on the next cycle.

Source files
------------

// File: rtl/xchk_pkg.sv
// Shared types for the bus X-check lane scheduler.
// Lanes 0..3 are the byte lanes of a 32-bit bus and lane 4 is the full word.
package xchk_pkg;

  localparam int unsigned NUM_LANES = 5;

  typedef enum logic [2:0] {
    LANE_B0 = 3'd0,
    LANE_B1 = 3'd1,
    LANE_B2 = 3'd2,
    LANE_B3 = 3'd3,
    LANE_W  = 3'd4
  } lane_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STARTUP = 2'd1,
    SCAN    = 2'd2
  } state_e;

  // Select encoding per lane, indexed by lane_e.
  localparam logic [NUM_LANES-1:0][3:0] SEL_ENC = {4'b1111, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

endpackage

// File: rtl/xchk_lane_picker.sv
// Combinational round-robin lane finder.
//   cur_lane_i    : lane the search starts after
//   mask_i        : per-lane enables
//   next_lane_o   : next enabled lane above cur_lane_i, wrapping 4 -> 0; cur_lane_i if it is
//                   the only enabled lane (or none is enabled)
//   any_enabled_o : at least one lane enabled
// Passing cur_lane_i = LANE_W yields the lowest enabled lane.
module xchk_lane_picker
  import xchk_pkg::*;
(
  input  lane_e                cur_lane_i,
  input  logic [NUM_LANES-1:0] mask_i,
  output lane_e                next_lane_o,
  output logic                 any_enabled_o
);

  logic [2:0] idx;

  always_comb begin
    next_lane_o = cur_lane_i;
    idx         = '0;
    // Walk from the farthest candidate to the nearest so the nearest enabled lane wins;
    // k == NUM_LANES lands back on cur_lane_i itself.
    for (int k = int'(NUM_LANES); k >= 1; k--) begin
      idx = 3'((int'(cur_lane_i) + k) % int'(NUM_LANES));
      if (mask_i[idx]) next_lane_o = lane_e'(idx);
    end
  end

  assign any_enabled_o = |mask_i;

endmodule

// File: rtl/xchk_lane_sched.sv
// Lane scheduler for the 32-bit bus X-checker (simulation-only monitor).
// After a startup hold-off it round-robins over the enabled lanes, samples each lane's bus
// slice on its last dwell cycle and records sticky X-error state.
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   enable           : run the scheduler; low returns to IDLE
//   lane_mask        : per-lane enables (0..3 bytes, 4 full word)
//   clear_errs       : clear error flags, count and first-error capture
//   bus              : observed data bus
//   select           : one-hot byte select, 1111 for word, 0000 when not scanning
//   sample_valid     : pulse on a sampled cycle
//   err_flags        : sticky per-lane X flags
//   err_count        : saturating X sample count
//   first_err_lane/first_err_valid : lane of the first error since the last clear
//   busy             : STARTUP or SCAN
module xchk_lane_sched
  import xchk_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES = 400,
  parameter int unsigned DWELL_CYCLES   = 4,
  parameter int unsigned ERR_CNT_W      = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_LANES-1:0] lane_mask,
  input  logic                 clear_errs,
  input  logic [31:0]          bus,
  output logic [3:0]           select,
  output logic                 sample_valid,
  output logic [NUM_LANES-1:0] err_flags,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [2:0]           first_err_lane,
  output logic                 first_err_valid,
  output logic                 busy
);

  localparam int unsigned SuW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

  state_e               state_q, state_d;
  logic [SuW-1:0]       su_cnt_q, su_cnt_d;
  logic [7:0]           dwell_q, dwell_d;
  lane_e                ptr_q, ptr_d;
  // Set while the pointer must be re-derived as the lowest enabled lane (scan entry, or
  // after the mask went to zero).
  logic                 rescan_q, rescan_d;
  logic [NUM_LANES-1:0] err_flags_q, err_flags_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [2:0]           first_lane_q, first_lane_d;
  logic                 first_valid_q, first_valid_d;

  lane_e first_lane, next_lane, eff_lane;
  logic  first_any, next_any, last_dwell, x_det, err_hit;

  xchk_lane_picker u_first (
    .cur_lane_i    (LANE_W),
    .mask_i        (lane_mask),
    .next_lane_o   (first_lane),
    .any_enabled_o (first_any)
  );

  xchk_lane_picker u_next (
    .cur_lane_i    (eff_lane),
    .mask_i        (lane_mask),
    .next_lane_o   (next_lane),
    .any_enabled_o (next_any)
  );

  assign eff_lane   = rescan_q ? first_lane : ptr_q;
  assign last_dwell = (dwell_q == 8'(DWELL_CYCLES - 1));

  // X shows up as an unknown reduction-XOR of the lane's slice.
  always_comb begin
    x_det = 1'b0;
    case (eff_lane)
      LANE_B0: x_det = $isunknown(^bus[7:0]);
      LANE_B1: x_det = $isunknown(^bus[15:8]);
      LANE_B2: x_det = $isunknown(^bus[23:16]);
      LANE_B3: x_det = $isunknown(^bus[31:24]);
      LANE_W:  x_det = $isunknown(^bus);
      default: x_det = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    su_cnt_d     = su_cnt_q;
    dwell_d      = dwell_q;
    ptr_d        = ptr_q;
    rescan_d     = rescan_q;
    select       = 4'b0000;
    sample_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = STARTUP;
          su_cnt_d = '0;
        end
      end
      STARTUP: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (su_cnt_q == SuW'(STARTUP_CYCLES - 1)) begin
          state_d  = SCAN;
          dwell_d  = '0;
          rescan_d = 1'b1;
        end else begin
          su_cnt_d = su_cnt_q + 1'b1;
        end
      end
      SCAN: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (!first_any) begin
          // No lane enabled: park with the dwell counter frozen.
          rescan_d = 1'b1;
        end else begin
          select   = SEL_ENC[eff_lane];
          rescan_d = 1'b0;
          ptr_d    = eff_lane;
          if (last_dwell) begin
            dwell_d      = '0;
            ptr_d        = next_any ? next_lane : eff_lane;
            // A lane disabled mid-dwell still advances but is not sampled.
            sample_valid = lane_mask[eff_lane];
          end else begin
            dwell_d = dwell_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_hit = sample_valid && x_det;

  // Clear first, so a same-cycle error starts a fresh record.
  always_comb begin
    err_flags_d   = err_flags_q;
    err_count_d   = err_count_q;
    first_lane_d  = first_lane_q;
    first_valid_d = first_valid_q;
    if (clear_errs) begin
      err_flags_d   = '0;
      err_count_d   = '0;
      first_lane_d  = '0;
      first_valid_d = 1'b0;
    end
    if (err_hit) begin
      err_flags_d[eff_lane] = 1'b1;
      if (err_count_d != '1) err_count_d = err_count_d + 1'b1;
      if (!first_valid_d) begin
        first_lane_d  = eff_lane;
        first_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      su_cnt_q      <= '0;
      dwell_q       <= '0;
      ptr_q         <= LANE_B0;
      rescan_q      <= 1'b0;
      err_flags_q   <= '0;
      err_count_q   <= '0;
      first_lane_q  <= '0;
      first_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      su_cnt_q      <= su_cnt_d;
      dwell_q       <= dwell_d;
      ptr_q         <= ptr_d;
      rescan_q      <= rescan_d;
      err_flags_q   <= err_flags_d;
      err_count_q   <= err_count_d;
      first_lane_q  <= first_lane_d;
      first_valid_q <= first_valid_d;
    end
  end

  assign err_flags       = err_flags_q;
  assign err_count       = err_count_q;
  assign first_err_lane  = first_lane_q;
  assign first_err_valid = first_valid_q;
  assign busy            = (state_q != IDLE);

endmodule
